// File: rtl/rf_dbg_pkg.sv
// Shared types and constants for register-file debug readers.
package rf_dbg_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_DEPTH  = 32;

  // Dump walker states.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks FIRST_ADDR..LAST_ADDR on one read port, snapshots
// each word and streams {addr, data, last} out over a valid/ready handshake.
module regfile_dump_reader
  import rf_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W     = RF_ADDR_W,
  parameter int unsigned DATA_W     = RF_DATA_W,
  parameter int unsigned FIRST_ADDR = 0,
  parameter int unsigned LAST_ADDR  = RF_DEPTH - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last
);

  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(LAST_ADDR);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  // Next-state logic: FSM walk, address counter and beat capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    beat_addr_d = beat_addr_q;
    last_d      = last_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort outranks start even while idle.
        if (start && !abort) begin
          state_d = StFetch;
          addr_d  = FirstAddr;
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StIdle;
          valid_d = 1'b0;
          addr_d  = FirstAddr;
        end else begin
          // Read data is combinational from the register file, so capture now.
          data_d      = rf_rd_data;
          beat_addr_d = addr_q;
          last_d      = (addr_q == LastAddr);
          valid_d     = 1'b1;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          // Pending beat is dropped even if dump_ready is high this cycle.
          state_d = StIdle;
          valid_d = 1'b0;
          addr_d  = FirstAddr;
        end else if (valid_q && dump_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
            addr_d  = FirstAddr;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        addr_d  = FirstAddr;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= FirstAddr;
      data_q      <= '0;
      beat_addr_q <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      beat_addr_q <= beat_addr_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  // Outputs come straight from registers; done only fires from IDLE so never overlaps busy.
  always_comb begin
    busy       = (state_q != StIdle);
    done       = done_q;
    rf_rd_addr = addr_q;
    dump_valid = valid_q;
    dump_data  = data_q;
    dump_addr  = beat_addr_q;
    dump_last  = last_q;
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural 32x32 register file.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, dump_ready;
  logic        busy, done, dump_valid, dump_last;
  logic [4:0]  rf_rd_addr, dump_addr;
  logic [31:0] rf_rd_data, dump_data;

  logic        start2;
  logic        busy2, done2, dump_valid2, dump_last2;
  logic [4:0]  rf_rd_addr2, dump_addr2;
  logic [31:0] rf_rd_data2, dump_data2;

  logic [31:0] rf [32];
  logic        poked20;
  int          checks = 0;
  int          errors = 0;
  int          nb, dc;

  always #5 clk = ~clk;

  assign rf_rd_data  = rf[rf_rd_addr];
  assign rf_rd_data2 = rf[rf_rd_addr2];

  regfile_dump_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_addr  (dump_addr),
    .dump_last  (dump_last)
  );

  regfile_dump_reader #(
    .FIRST_ADDR (31),
    .LAST_ADDR  (31)
  ) dut_single (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .abort      (1'b0),
    .busy       (busy2),
    .done       (done2),
    .rf_rd_addr (rf_rd_addr2),
    .rf_rd_data (rf_rd_data2),
    .dump_valid (dump_valid2),
    .dump_ready (1'b1),
    .dump_data  (dump_data2),
    .dump_addr  (dump_addr2),
    .dump_last  (dump_last2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One dump from addr 0 with optional stall / snapshot poke / restart / abort / reset points.
  task automatic run_dump(input int stall_at, input int snap_at, input int restart_at,
                          input int abort_at, input int rst_at,
                          output int nbeats, output int done_cyc);
    int          a;
    logic [31:0] expd;
    nbeats   = 0;
    done_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("fetch_busy", 64'(busy), 64'd1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (dump_valid) begin
        a    = nbeats;
        expd = (a == 20 && poked20) ? 32'hCAFEF00D : 32'(a) * 32'h01010101;
        check("beat_addr", 64'(dump_addr), 64'(a));
        check("beat_data", 64'(dump_data), 64'(expd));
        check("beat_last", 64'(dump_last), 64'(a == 31));
        check("beat_rdaddr", 64'(rf_rd_addr), 64'(a));
        nbeats++;
        if (a == stall_at) begin
          dump_ready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(dump_valid), 64'd1);
            check("stall_addr", 64'(dump_addr), 64'(a));
            check("stall_data", 64'(dump_data), 64'(expd));
            check("stall_rdaddr", 64'(rf_rd_addr), 64'(a));
          end
          dump_ready = 1'b1;
        end
        if (a == snap_at) begin
          rf[a]      = 32'hDEADBEEF;
          rf[20]     = 32'hCAFEF00D;
          poked20    = 1'b1;
          dump_ready = 1'b0;
          @(negedge clk);
          check("snap_data", 64'(dump_data), 64'(expd));
          dump_ready = 1'b1;
        end
        if (a == restart_at) start = 1'b1;
        if (a == abort_at) begin
          abort = 1'b1;
          @(negedge clk); abort = 1'b0;
          check("abort_valid", 64'(dump_valid), 64'd0);
          check("abort_busy", 64'(busy), 64'd0);
          check("abort_done", 64'(done), 64'd0);
          check("abort_rdaddr", 64'(rf_rd_addr), 64'd0);
          @(negedge clk);
          check("abort_done2", 64'(done), 64'd0);
          return;
        end
        if (a == rst_at) begin
          reset = 1'b1;
          @(negedge clk); reset = 1'b0;
          check("rst_valid", 64'(dump_valid), 64'd0);
          check("rst_busy", 64'(busy), 64'd0);
          check("rst_done", 64'(done), 64'd0);
          check("rst_data", 64'(dump_data), 64'd0);
          check("rst_addr", 64'(dump_addr), 64'd0);
          check("rst_last", 64'(dump_last), 64'd0);
          check("rst_rdaddr", 64'(rf_rd_addr), 64'd0);
          @(negedge clk);
          check("rst_done2", 64'(done), 64'd0);
          return;
        end
      end
      if (done) begin
        done_cyc = cyc;
        check("done_busy", 64'(busy), 64'd0);
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b1; start2 = 1'b0;
    poked20 = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_valid", 64'(dump_valid), 64'd0);
    check("reset_data", 64'(dump_data), 64'd0);
    check("reset_addr", 64'(dump_addr), 64'd0);
    check("reset_last", 64'(dump_last), 64'd0);
    check("reset_rdaddr", 64'(rf_rd_addr), 64'd0);
    check("reset_rdaddr2", 64'(rf_rd_addr2), 64'd31);

    // Full dump, no backpressure.
    run_dump(-1, -1, -1, -1, -1, nb, dc);
    check("full_beats", 64'(nb), 64'd32);
    check("full_done_cycle", 64'(dc), 64'd64);
    @(negedge clk);
    check("full_done_pulse", 64'(done), 64'd0);
    check("full_busy_after", 64'(busy), 64'd0);

    // Backpressure at 3, snapshot at 5, start while busy at 7.
    run_dump(3, 5, 7, -1, -1, nb, dc);
    check("bp_beats", 64'(nb), 64'd32);
    check("bp_done_seen", 64'(dc >= 0), 64'd1);
    rf[5]   = 32'h05050505;
    rf[20]  = 32'h14141414;
    poked20 = 1'b0;

    // start and abort together while idle.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("sa_busy", 64'(busy), 64'd0);
    check("sa_valid", 64'(dump_valid), 64'd0);
    @(negedge clk);
    check("sa_busy2", 64'(busy), 64'd0);

    // Abort at 10, then a clean dump from 0.
    run_dump(-1, -1, -1, 10, -1, nb, dc);
    check("abort_beats", 64'(nb), 64'd11);
    run_dump(-1, -1, -1, -1, -1, nb, dc);
    check("after_abort_beats", 64'(nb), 64'd32);

    // Synchronous reset at 12.
    run_dump(-1, -1, -1, -1, 12, nb, dc);
    check("rst_beats", 64'(nb), 64'd13);

    // Single-beat instance: FIRST_ADDR == LAST_ADDR == 31.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    check("one_busy", 64'(busy2), 64'd1);
    check("one_valid0", 64'(dump_valid2), 64'd0);
    @(negedge clk);
    check("one_valid", 64'(dump_valid2), 64'd1);
    check("one_addr", 64'(dump_addr2), 64'd31);
    check("one_last", 64'(dump_last2), 64'd1);
    check("one_data", 64'(dump_data2), 64'h1F1F1F1F);
    @(negedge clk);
    check("one_done", 64'(done2), 64'd1);
    check("one_busy_done", 64'(busy2), 64'd0);
    check("one_valid_done", 64'(dump_valid2), 64'd0);
    @(negedge clk);
    check("one_done_pulse", 64'(done2), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
